reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file with rename tags for the Tomasulo core.
- Responder to the decoder's operand queries: returns value, ready flag and producing ROB index per source register.
- Records destination renames on issue, retires values on ROB commit, and clears all renames on rollback.
- Sits between decoder (query/issue side) and ROB (commit side).

Parameters:
- DATA_W, 32, register data width.
- REG_W, 5, register index width (32 registers).
- ROB_W, 4, ROB index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rdy  in  1  global enable; state frozen when low.
- rollback  in  1  misprediction flush from ROB.
- reg_rs1  in  REG_W  source-1 index from decoder.
- reg_rs1_rdy  out  1  source-1 value valid.
- reg_rs1_val  out  DATA_W  source-1 value.
- reg_rs1_rob_pos  out  ROB_W  ROB entry producing source-1.
- reg_rs2  in  REG_W  source-2 index.
- reg_rs2_rdy  out  1  source-2 value valid.
- reg_rs2_val  out  DATA_W  source-2 value.
- reg_rs2_rob_pos  out  ROB_W  ROB entry producing source-2.
- issue  in  1  decoder issues an instruction this cycle.
- issue_rd  in  REG_W  destination of issued instruction.
- issue_rob_pos  in  ROB_W  ROB entry allocated to it.
- commit  in  1  ROB retires an instruction this cycle.
- commit_rd  in  REG_W  retired destination.
- commit_val  in  DATA_W  retired value.
- commit_rob_pos  in  ROB_W  retired ROB entry.

Behaviour:
- Reset: rst is synchronous, active-high.
  - On a clk edge with rst=1, every value, busy bit and tag is set to 0.
  - rst has priority over rdy.
  - While rst=1, all query outputs are forced to rdy=1, val=0, rob_pos=0.
- Storage: per register i, val[i] (DATA_W), busy[i] (1), tag[i] (ROB_W).
- Query path, combinational, same-cycle:
  - x0: rdy=1, val=0, rob_pos=0, always.
  - busy[i]=1: rdy=0, val=0, rob_pos=tag[i].
  - busy[i]=0: rdy=1, val=val[i], rob_pos=0.
- Sequential update, on posedge when rdy=1 and rst=0, applied in this order:
  1. Commit: if commit and commit_rd!=0, write val[commit_rd]=commit_val. If busy[commit_rd] and tag[commit_rd]==commit_rob_pos, clear busy. A tag mismatch means a newer writer owns the register: value is written, busy/tag untouched.
  2. Rollback: if rollback, clear busy for all 32 registers. Tags are don't-care. The step-1 commit write still takes effect.
  3. Issue: if issue, !rollback and issue_rd!=0, set busy[issue_rd]=1 and tag[issue_rd]=issue_rob_pos. This overrides a same-cycle busy clear from step 1 on the same register.
- Writes or issues to x0 are ignored; val[0] stays 0.
- Query outputs reflect pre-edge state. A same-cycle issue is visible on the next cycle only, so a decoder issuing A then B reads A's rename in B's cycle.
- rdy=0: no state change; queries still answer combinationally.
- Latency: query 0 cycles; issue/commit/rollback effect visible 1 cycle after the edge.

Optional Feature:
- Macro COMMIT_BYPASS_EN.
- Defined: if commit=1 this cycle, commit_rd!=0, commit_rd equals the queried index, the register is busy and tag==commit_rob_pos, the query returns rdy=1, val=commit_val, rob_pos=0 in the same cycle. Applies independently to rs1 and rs2.
- Undefined: no forwarding; the query shows rdy=0 with the tag until the edge.

Test Plan:
- Reset then query rs1=5, rs2=0 -> both rdy=1, val=0, rob_pos=0.
- Issue rd=3, rob=7; next cycle query rs1=3 -> rdy=0, rob_pos=7. Commit rd=3, val=0xDEADBEEF, rob=7; next cycle -> rdy=1, val=0xDEADBEEF.
- Issue rd=4 rob=2, then issue rd=4 rob=9, then commit rd=4 val=0x11 rob=2 -> rs1=4 shows rdy=0, rob_pos=9; val[4]=0x11 internally. Commit rob=9 val=0x22 -> rdy=1, val=0x22.
- Same cycle: commit rd=6 rob=1 (tag matches) and issue rd=6 rob=3 -> next cycle rdy=0, rob_pos=3.
- Registers 1, 2, 8 busy; rollback with commit rd=2 val=0x55 -> next cycle all three rdy=1, reg2 val=0x55. A same-cycle issue rd=10 is ignored: reg10 rdy=1.
- Issue/commit to x0 with val=0xFFFF -> x0 still rdy=1, val=0. With COMMIT_BYPASS_EN: busy reg 5 tag 4, commit rd=5 rob=4 val=0x77 -> same-cycle query rdy=1, val=0x77. Without it -> rdy=0, rob_pos=4.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: architectural register file with rename tags for the Tomasulo core.
// Answers decoder operand queries combinationally, records destination
// renames on issue, retires values on ROB commit and clears all renames on
// rollback. Register x0 is hardwired to zero and is never renamed.
//
// Optional build macro: COMMIT_BYPASS_EN. When defined, a commit that
// completes the queried register's current rename is forwarded to the query
// outputs in the same cycle.
//
// Strobe semantics: issue, commit and rollback are single-cycle qualifiers.
// Each one is consumed on a rising clk edge where rdy=1 and rst=0, and it has
// no effect on any other edge. There is no back-pressure, so the register
// file accepts every qualified strobe.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic [REG_W-1:0]  reg_rs1,
  output logic              reg_rs1_rdy,
  output logic [DATA_W-1:0] reg_rs1_val,
  output logic [ROB_W-1:0]  reg_rs1_rob_pos,
  input  logic [REG_W-1:0]  reg_rs2,
  output logic              reg_rs2_rdy,
  output logic [DATA_W-1:0] reg_rs2_val,
  output logic [ROB_W-1:0]  reg_rs2_rob_pos,
  input  logic              issue,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [ROB_W-1:0]  issue_rob_pos,
  input  logic              commit,
  input  logic [REG_W-1:0]  commit_rd,
  input  logic [DATA_W-1:0] commit_val,
  input  logic [ROB_W-1:0]  commit_rob_pos
);

  localparam int NREG = 1 << REG_W;

  logic [DATA_W-1:0] val_q [NREG];
  logic [DATA_W-1:0] val_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [ROB_W-1:0]  tag_q [NREG];
  logic [ROB_W-1:0]  tag_d [NREG];

  // Next state: commit first, then rollback, then issue (issue wins over a
  // same-register busy clear from the commit).
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit && (commit_rd != '0)) begin
      val_d[commit_rd] = commit_val;
      // A tag mismatch means a newer writer still owns the register.
      if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_pos)) begin
        busy_d[commit_rd] = 1'b0;
      end
    end
    if (rollback) begin
      busy_d = '0;
    end
    if (issue && !rollback && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rob_pos;
    end
  end

  // State registers: synchronous reset clears everything; rdy=0 freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else if (rdy) begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Source-1 query: pre-edge state, forced ready/zero during reset and for x0.
  always_comb begin
    reg_rs1_rdy     = 1'b1;
    reg_rs1_val     = '0;
    reg_rs1_rob_pos = '0;
    if (!rst && (reg_rs1 != '0)) begin
      if (busy_q[reg_rs1]) begin
`ifdef COMMIT_BYPASS_EN
        if (commit && (commit_rd == reg_rs1) && (tag_q[reg_rs1] == commit_rob_pos)) begin
          reg_rs1_val = commit_val;
        end else begin
          reg_rs1_rdy     = 1'b0;
          reg_rs1_rob_pos = tag_q[reg_rs1];
        end
`else
        reg_rs1_rdy     = 1'b0;
        reg_rs1_rob_pos = tag_q[reg_rs1];
`endif
      end else begin
        reg_rs1_val = val_q[reg_rs1];
      end
    end
  end

  // Source-2 query: identical rules to source 1, evaluated independently.
  always_comb begin
    reg_rs2_rdy     = 1'b1;
    reg_rs2_val     = '0;
    reg_rs2_rob_pos = '0;
    if (!rst && (reg_rs2 != '0)) begin
      if (busy_q[reg_rs2]) begin
`ifdef COMMIT_BYPASS_EN
        if (commit && (commit_rd == reg_rs2) && (tag_q[reg_rs2] == commit_rob_pos)) begin
          reg_rs2_val = commit_val;
        end else begin
          reg_rs2_rdy     = 1'b0;
          reg_rs2_rob_pos = tag_q[reg_rs2];
        end
`else
        reg_rs2_rdy     = 1'b0;
        reg_rs2_rob_pos = tag_q[reg_rs2];
`endif
      end else begin
        reg_rs2_val = val_q[reg_rs2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plus randomized stimulus for reg_file, checked
// against a behavioural model of the architectural register file.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic [4:0]  reg_rs1;
  logic        reg_rs1_rdy;
  logic [31:0] reg_rs1_val;
  logic [3:0]  reg_rs1_rob_pos;
  logic [4:0]  reg_rs2;
  logic        reg_rs2_rdy;
  logic [31:0] reg_rs2_val;
  logic [3:0]  reg_rs2_rob_pos;
  logic        issue;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;
  logic        commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_pos;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .reg_rs1(reg_rs1), .reg_rs1_rdy(reg_rs1_rdy), .reg_rs1_val(reg_rs1_val),
    .reg_rs1_rob_pos(reg_rs1_rob_pos),
    .reg_rs2(reg_rs2), .reg_rs2_rdy(reg_rs2_rdy), .reg_rs2_val(reg_rs2_val),
    .reg_rs2_rob_pos(reg_rs2_rob_pos),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_pos(commit_rob_pos)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {rdy, val, rob_pos} for a query of register idx this cycle.
  function automatic logic [36:0] model_q(input logic [4:0] idx);
    if (rst || idx == 5'd0) return {1'b1, 32'd0, 4'd0};
    if (m_busy[idx]) begin
`ifdef COMMIT_BYPASS_EN
      if (commit && commit_rd == idx && m_tag[idx] == commit_rob_pos)
        return {1'b1, commit_val, 4'd0};
`endif
      return {1'b0, 32'd0, m_tag[idx]};
    end
    return {1'b1, m_val[idx], 4'd0};
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy) begin
      if (commit && commit_rd != 0) begin
        m_val[commit_rd] = commit_val;
        if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_pos) m_busy[commit_rd] = 1'b0;
      end
      if (rollback) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      if (issue && !rollback && issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_rob_pos;
      end
    end
  endtask

  // Check queries before the edge, clock once, advance the model, idle strobes.
  task automatic step();
    logic [36:0] e1, e2;
    #1;
    e1 = model_q(reg_rs1);
    e2 = model_q(reg_rs2);
    check("rs1_rdy", 64'(reg_rs1_rdy), 64'(e1[36]));
    check("rs1_val", 64'(reg_rs1_val), 64'(e1[35:4]));
    check("rs1_pos", 64'(reg_rs1_rob_pos), 64'(e1[3:0]));
    check("rs2_rdy", 64'(reg_rs2_rdy), 64'(e2[36]));
    check("rs2_val", 64'(reg_rs2_val), 64'(e2[35:4]));
    check("rs2_pos", 64'(reg_rs2_rob_pos), 64'(e2[3:0]));
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; issue = 1'b0; commit = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] rob);
    issue = 1'b1; issue_rd = rd; issue_rob_pos = rob;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] rob);
    commit = 1'b1; commit_rd = rd; commit_val = v; commit_rob_pos = rob;
  endtask

  task automatic query(input logic [4:0] a, input logic [4:0] b);
    reg_rs1 = a; reg_rs2 = b;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    issue = 1'b0; issue_rd = '0; issue_rob_pos = '0;
    commit = 1'b0; commit_rd = '0; commit_val = '0; commit_rob_pos = '0;
    query(5, 0);
    step();                                   // during reset: forced outputs
    query(5, 0); step();                      // after reset

    // Rename then retire
    do_issue(3, 7); step();
    query(3, 0); step();
    do_commit(3, 32'hDEADBEEF, 7); query(3, 3); step();
    query(3, 0); step();

    // Stale commit leaves the newer rename in place
    do_issue(4, 2); step();
    do_issue(4, 9); step();
    do_commit(4, 32'h11, 2); query(4, 0); step();
    query(4, 4); step();
    do_commit(4, 32'h22, 9); step();
    query(4, 0); step();

    // Same-cycle commit and re-issue of one register
    do_issue(6, 1); step();
    do_commit(6, 32'h66, 1); do_issue(6, 3); query(6, 6); step();
    query(6, 0); step();

    // Rollback with a same-cycle commit and a suppressed issue
    do_issue(1, 5); step();
    do_issue(2, 6); step();
    do_issue(8, 8); query(1, 2); step();
    do_commit(2, 32'h55, 12); rollback = 1'b1; do_issue(10, 11); query(2, 8); step();
    query(1, 2); step();
    query(8, 10); step();

    // x0 is never written or renamed
    do_issue(0, 15); do_commit(0, 32'hFFFF, 15); query(0, 0); step();
    query(0, 0); step();

    // Same-cycle forwarding of a completing commit
    do_issue(5, 4); step();
    do_commit(5, 32'h77, 4); query(5, 0); step();
    query(5, 5); step();

    // rdy low freezes state
    rdy = 1'b0; do_issue(7, 5); do_commit(9, 32'h99, 0); query(7, 9); step();
    query(7, 9); step();

    // Reset with live renames
    do_issue(12, 3); step();
    rst = 1'b1; query(12, 3); step();
    query(12, 3); step();

    // Randomized phase over a small register window to force interactions
    for (int n = 0; n < 400; n++) begin
      query(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) < 50) do_issue(5'($urandom_range(0, 7)), 4'($urandom));
      if ($urandom_range(0, 99) < 50) begin
        commit = 1'b1;
        commit_rd = 5'($urandom_range(0, 7));
        commit_val = $urandom;
        commit_rob_pos = ($urandom_range(0, 1) == 1) ? m_tag[commit_rd] : 4'($urandom);
        if ($urandom_range(0, 2) == 0) reg_rs1 = commit_rd;
      end
      if ($urandom_range(0, 99) < 5)  rollback = 1'b1;
      if ($urandom_range(0, 99) < 10) rdy = 1'b0;
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
